nibble_serial_comparator_ctrl: RTL
==================================

Name: nibble_serial_comparator_ctrl

Overview:
- Sequencer that compares two WIDTH-bit operands using one shared external 4-bit magnitude comparator (the bit4_comparator block).
- Presents one nibble pair per cycle, starting at the MSB nibble, and stops at the first unequal nibble.
- Reports an equal/greater/less verdict with a done pulse.
- Lets wide compares (addresses, counters) reuse the single 4-bit comparator instead of instantiating a wide one.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 4.
- NIBBLES, WIDTH/4, derived; not to be overridden.
- CW, $clog2(NIBBLES+1), derived width of nibbles_used.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; accepted only when busy=0.
- op_a  input  WIDTH  operand A; sampled on the accepting edge.
- op_b  input  WIDTH  operand B; sampled on the accepting edge.
- busy  output  1  high while a compare is in progress (COMPARE or DONE).
- done  output  1  one-cycle pulse; verdict is valid from this cycle on.
- equal  output  1  verdict: A == B.
- greater  output  1  verdict: A > B (unsigned).
- less  output  1  verdict: A < B (unsigned).
- err  output  1  comparator returned a non-one-hot response.
- nibbles_used  output  CW  number of nibble pairs examined (1..NIBBLES).
- cmp_a  output  4  nibble of A driven to the comparator.
- cmp_b  output  4  nibble of B driven to the comparator.
- cmp_equal  input  1  comparator equal output.
- cmp_greater  input  1  comparator greater output.
- cmp_less  input  1  comparator less output.

Behaviour:
- Reset (async, applied immediately, also mid-operation):
  - state=IDLE.
  - All outputs, operand registers and the index are 0.
  - Any compare in progress is dropped with no done pulse.
- The comparator is combinational. Its flags are sampled in the same cycle that cmp_a/cmp_b are driven.
- FSM IDLE:
  - busy=0; cmp_a=cmp_b=0.
  - On start=1: latch op_a/op_b, set idx=NIBBLES-1, clear equal/greater/less/err/nibbles_used, go to COMPARE.
- FSM COMPARE:
  - busy=1; cmp_a=a_reg[4*idx+:4], cmp_b=b_reg[4*idx+:4].
  - Flags not exactly one-hot: err=1, equal/greater/less=0, go to DONE.
  - Else cmp_equal=1 and idx>0: idx decrements, stay in COMPARE.
  - Else (unequal, or idx==0): latch the flags into equal/greater/less, go to DONE.
  - nibbles_used is loaded with the count examined, including the deciding nibble.
- FSM DONE:
  - busy=1; done=1 for exactly this cycle; next state IDLE.
- Latency:
  - If start is accepted at edge T0 and k nibbles are examined, done is high during the cycle after edge T0+k.
  - Minimum k=1 (MSB nibble differs); maximum k=NIBBLES (equal operands or LSB-only difference).
- Verdict hold: equal/greater/less/err/nibbles_used hold their values until the next accepted start.
- start while busy=1 (including the DONE cycle) is ignored, not queued. Back-to-back: the earliest new accept is the edge after DONE.
- Operand changes after the accepting edge have no effect on the result.
- Exactly one of equal/greater/less is 1 after a non-error compare. All three are 0 when err=1.
- cmp_a/cmp_b are 0 outside COMPARE.

Test Plan (WIDTH=16, behavioural one-hot comparator model unless stated):
- op_a=16'hABCD, op_b=16'hABCD, start pulse -> 4 COMPARE cycles; done 5 cycles after the start edge; equal=1, greater=0, less=0, nibbles_used=4.
- op_a=16'h8000, op_b=16'h7FFF -> done after 1 COMPARE cycle; greater=1, nibbles_used=1; cmp_a=4'h8, cmp_b=4'h7 during COMPARE.
- op_a=16'h1234, op_b=16'h1235 -> less=1, nibbles_used=4; cmp_a sequence 1,2,3,4.
- op_a=16'h0F00, op_b=16'h0E00; after acceptance change op_a to 16'h0000 and pulse start twice while busy -> still greater=1, nibbles_used=2, exactly one done pulse.
- Comparator model forced to greater=1 and less=1 on the first nibble -> err=1, equal/greater/less=0, nibbles_used=1, done pulses once.
- Start the 16'hABCD/16'hABCD compare and assert rst during the second COMPARE cycle -> busy/cmp_a/equal go to 0 immediately, no done pulse. After release, op_a=16'h0001, op_b=16'h0002 -> less=1, nibbles_used=4.

Source files
------------

// File: rtl/nibble_serial_comparator_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_comparator_ctrl
//  Description : Compares two WIDTH-bit operands one nibble pair per cycle,
//                MSB nibble first, through a shared external 4-bit magnitude
//                comparator. Stops at the first unequal nibble and reports an
//                equal/greater/less verdict with a single-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_comparator_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4,
    parameter int CW      = $clog2(NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             less,
    output logic             err,
    output logic [CW-1:0]    nibbles_used,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    input  logic             cmp_less
);

    // Index width; a single-nibble configuration still needs one bit.
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic             w_onehot;
    logic [CW-1:0]    w_count;

    logic             w_accept;
    logic             w_step;
    logic             w_finish;
    logic             w_fault;

    // Anything other than exactly one asserted flag is a comparator fault.
    assign w_onehot = ( cmp_equal & ~cmp_greater & ~cmp_less) |
                      (~cmp_equal &  cmp_greater & ~cmp_less) |
                      (~cmp_equal & ~cmp_greater &  cmp_less);

    // Nibbles examined so far, counting the one currently on the comparator.
    assign w_count = CW'(NIBBLES) - CW'(r_idx);

    // Select the nibble pair addressed by the current index.
    always_comb begin
        w_nib_a = 4'h0;
        w_nib_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib_a = r_a[4*i +: 4];
                w_nib_b = r_b[4*i +: 4];
            end
        end
    end

    // State register; reset drops any compare in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_fault     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cmp_a       = 4'h0;
        cmp_b       = 4'h0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                busy  = 1'b1;
                cmp_a = w_nib_a;
                cmp_b = w_nib_b;
                if (!w_onehot) begin
                    w_fault     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (cmp_equal && (r_idx != '0)) begin
                    w_step      = 1'b1;
                end else begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, index walk and verdict registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_idx        <= '0;
            equal        <= 1'b0;
            greater      <= 1'b0;
            less         <= 1'b0;
            err          <= 1'b0;
            nibbles_used <= '0;
        end else if (w_accept) begin
            r_a          <= op_a;
            r_b          <= op_b;
            r_idx        <= IW'(NIBBLES - 1);
            equal        <= 1'b0;
            greater      <= 1'b0;
            less         <= 1'b0;
            err          <= 1'b0;
            nibbles_used <= '0;
        end else if (w_step) begin
            r_idx        <= r_idx - IW'(1);
        end else if (w_fault) begin
            equal        <= 1'b0;
            greater      <= 1'b0;
            less         <= 1'b0;
            err          <= 1'b1;
            nibbles_used <= w_count;
        end else if (w_finish) begin
            equal        <= cmp_equal;
            greater      <= cmp_greater;
            less         <= cmp_less;
            nibbles_used <= w_count;
        end
    end

endmodule
`default_nettype wire
